// File: rtl/address_mapper_pkg.sv
// Shared types and constants for the SNES address mapper.
// Mapper mode encoding plus the save-RAM and menu ROM base addresses.
package address_mapper_pkg;

    typedef enum logic [2:0] {
        MAP_HIROM   = 3'd0,
        MAP_LOROM   = 3'd1,
        MAP_EXHIROM = 3'd2,
        MAP_MENU    = 3'd3
    } mapper_e;

    localparam logic [23:0] SAVE_BASE     = 24'hFF0000;
    localparam logic [23:0] MENU_ROM_BASE = 24'hC00000;

endpackage

// File: rtl/address_decode.sv
// Combinational per-mode SNES address decode.
// Ports: mapper, addr, smask, rmask in; rom_addr, is_rom, is_saveram out.
module address_decode
    import address_mapper_pkg::*;
(
    input  logic [2:0]  mapper,
    input  logic [23:0] addr,
    input  logic [23:0] smask,
    input  logic [23:0] rmask,
    output logic [23:0] rom_addr,
    output logic        is_rom,
    output logic        is_saveram
);

    // Save window offset; wraps in 15 bits before widening.
    logic [14:0] off15;
    logic [23:0] hi_save;
    logic [23:0] lo_save;
    logic [23:0] menu_save;
    logic [23:0] hi_rom;
    logic [23:0] lo_rom;
    logic [23:0] ex_rom;
    logic [23:0] menu_rom;
    logic        bank_ok;
    logic        save;
    logic        rom;
    logic [23:0] save_a;
    logic [23:0] rom_a;

    assign off15   = addr[14:0] - 15'h6000;
    // Banks 0x7E/0x7F are WRAM in LoROM.
    assign bank_ok = (addr[23:17] != 7'h3F);

    assign hi_save = SAVE_BASE
                   + (({6'b0, addr[20:16], 13'b0}
                      + {9'b0, off15}) & smask);
    assign lo_save = SAVE_BASE
                   + ({5'b0, addr[19:16], addr[14:0]} & smask);
    assign menu_save = SAVE_BASE + ({9'b0, off15} & smask);

    assign hi_rom   = {2'b0, addr[21:0]} & rmask;
    assign lo_rom   = {2'b0, addr[22:16], addr[14:0]} & rmask;
    assign ex_rom   = {1'b0, ~addr[23], addr[21:0]} & rmask;
    assign menu_rom = ({1'b0, addr[22:0]} & rmask) + MENU_ROM_BASE;

    always_comb begin
        save   = 1'b0;
        rom    = 1'b0;
        save_a = '0;
        rom_a  = '0;
        case (mapper)
            MAP_HIROM: begin
                save   = ~addr[22] & addr[21] & ~addr[15]
                       & addr[14] & addr[13];
                rom    = addr[22] | addr[15];
                save_a = hi_save;
                rom_a  = hi_rom;
            end
            MAP_LOROM: begin
                save   = addr[22] & addr[21] & addr[20]
                       & ~addr[15] & bank_ok;
                rom    = addr[15] | (addr[22] & ~save & bank_ok);
                save_a = lo_save;
                rom_a  = lo_rom;
            end
            MAP_EXHIROM: begin
                save   = addr[23] & ~addr[22] & addr[21]
                       & ~addr[15] & addr[14] & addr[13];
                rom    = addr[22] | addr[15];
                save_a = hi_save;
                rom_a  = ex_rom;
            end
            MAP_MENU: begin
                save   = ~addr[22] & addr[21] & addr[20]
                       & ~addr[15] & addr[14] & addr[13];
                rom    = addr[22] | addr[15];
                save_a = menu_save;
                rom_a  = menu_rom;
            end
            default: begin
                save   = 1'b0;
                rom    = 1'b0;
                save_a = '0;
                rom_a  = '0;
            end
        endcase
    end

    assign is_saveram = save;
    assign is_rom     = rom & ~save;
    assign rom_addr   = save ? save_a : rom_a;

endmodule

// File: rtl/address_mapper.sv
// Two-stage SNES address mapper with deferred config load and save tracking.
// Ports: CLK/RST, SNES_ADDR/ADDR_STB/SNES_WR bus in, CFG_* config load,
// ROM_ADDR/ROM_HIT/IS_ROM/IS_SAVERAM/MAP_VALID result,
// SAVERAM_DIRTY/DIRTY_CLR/SAVE_QUIET save-write tracking.
module address_mapper
    import address_mapper_pkg::*;
#(
    parameter int QUIET_CYCLES = 1024,
    parameter int RESET_MAPPER = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [23:0] SNES_ADDR,
    input  logic        ADDR_STB,
    input  logic        SNES_WR,
    input  logic [2:0]  CFG_MAPPER,
    input  logic [23:0] CFG_SAVERAM_MASK,
    input  logic [23:0] CFG_ROM_MASK,
    input  logic        CFG_STB,
    output logic        CFG_ACK,
    output logic [23:0] ROM_ADDR,
    output logic        ROM_HIT,
    output logic        IS_ROM,
    output logic        IS_SAVERAM,
    output logic        MAP_VALID,
    output logic        SAVERAM_DIRTY,
    input  logic        DIRTY_CLR,
    output logic        SAVE_QUIET
);

    localparam logic [15:0] Q_MAX  = 16'(QUIET_CYCLES);
    localparam logic [15:0] Q_LAST = 16'(QUIET_CYCLES - 1);

    logic        s1_v;
    logic [23:0] s1_addr;
    logic        s1_wr;
    logic        s2_v;
    logic        s2_wr;
    logic [23:0] s2_addr;
    logic        s2_rom;
    logic        s2_save;

    logic [2:0]  mode;
    logic [23:0] smask;
    logic [23:0] rmask;
    logic        pend_v;
    logic [2:0]  pend_mode;
    logic [23:0] pend_smask;
    logic [23:0] pend_rmask;
    logic        apply;

    logic [23:0] dec_addr;
    logic        dec_rom;
    logic        dec_save;

    logic        dirty;
    logic [15:0] cnt;
    logic        quiet;
    logic        save_hit;

    address_decode u_decode (
        .mapper     (mode),
        .addr       (s1_addr),
        .smask      (smask),
        .rmask      (rmask),
        .rom_addr   (dec_addr),
        .is_rom     (dec_rom),
        .is_saveram (dec_save)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v    <= 1'b0;
            s1_addr <= '0;
            s1_wr   <= 1'b0;
            s2_v    <= 1'b0;
            s2_wr   <= 1'b0;
            s2_addr <= '0;
            s2_rom  <= 1'b0;
            s2_save <= 1'b0;
        end else begin
            s1_v <= ADDR_STB;
            if (ADDR_STB) begin
                s1_addr <= SNES_ADDR;
                s1_wr   <= SNES_WR;
            end
            s2_v <= s1_v;
            // Results hold between valid pulses.
            if (s1_v) begin
                s2_addr <= dec_addr;
                s2_rom  <= dec_rom;
                s2_save <= dec_save;
                s2_wr   <= s1_wr;
            end
        end
    end

    // Config swaps only with an empty pipe so in-flight
    // accesses finish under the mode they started with.
    assign apply   = pend_v & ~ADDR_STB & ~s1_v & ~s2_v;
    assign CFG_ACK = apply & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode       <= 3'(RESET_MAPPER);
            smask      <= 24'h000000;
            rmask      <= 24'hFFFFFF;
            pend_v     <= 1'b0;
            pend_mode  <= '0;
            pend_smask <= '0;
            pend_rmask <= '0;
        end else begin
            if (apply) begin
                mode  <= pend_mode;
                smask <= pend_smask;
                rmask <= pend_rmask;
            end
            // A strobe racing an apply stays pending for the next idle slot.
            if (CFG_STB) begin
                pend_v     <= 1'b1;
                pend_mode  <= CFG_MAPPER;
                pend_smask <= CFG_SAVERAM_MASK;
                pend_rmask <= CFG_ROM_MASK;
            end else if (apply) begin
                pend_v <= 1'b0;
            end
        end
    end

    assign save_hit = s2_v & s2_save & s2_wr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            dirty <= 1'b0;
            cnt   <= '0;
            quiet <= 1'b0;
        end else begin
            quiet <= 1'b0;
            if (save_hit) begin
                dirty <= 1'b1;
                cnt   <= '0;
            end else if (DIRTY_CLR) begin
                dirty <= 1'b0;
                cnt   <= '0;
            end else if (dirty && cnt != Q_MAX) begin
                cnt   <= cnt + 16'd1;
                quiet <= (cnt == Q_LAST);
            end
        end
    end

    assign MAP_VALID     = s2_v;
    assign ROM_ADDR      = s2_addr;
    assign IS_ROM        = s2_rom;
    assign IS_SAVERAM    = s2_save;
    assign ROM_HIT       = s2_rom | s2_save;
    assign SAVERAM_DIRTY = dirty;
    assign SAVE_QUIET    = quiet;

endmodule

// File: tb/tb_address_mapper.sv
// Scoreboard bench for address_mapper.
// Directed strobes push expected results; a monitor pops on MAP_VALID.
module tb_address_mapper;

    logic        CLK = 1'b0;
    logic        RST;
    logic [23:0] SNES_ADDR;
    logic        ADDR_STB;
    logic        SNES_WR;
    logic [2:0]  CFG_MAPPER;
    logic [23:0] CFG_SAVERAM_MASK;
    logic [23:0] CFG_ROM_MASK;
    logic        CFG_STB;
    logic        CFG_ACK;
    logic [23:0] ROM_ADDR;
    logic        ROM_HIT;
    logic        IS_ROM;
    logic        IS_SAVERAM;
    logic        MAP_VALID;
    logic        SAVERAM_DIRTY;
    logic        DIRTY_CLR;
    logic        SAVE_QUIET;

    address_mapper #(
        .QUIET_CYCLES (16)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .SNES_ADDR        (SNES_ADDR),
        .ADDR_STB         (ADDR_STB),
        .SNES_WR          (SNES_WR),
        .CFG_MAPPER       (CFG_MAPPER),
        .CFG_SAVERAM_MASK (CFG_SAVERAM_MASK),
        .CFG_ROM_MASK     (CFG_ROM_MASK),
        .CFG_STB          (CFG_STB),
        .CFG_ACK          (CFG_ACK),
        .ROM_ADDR         (ROM_ADDR),
        .ROM_HIT          (ROM_HIT),
        .IS_ROM           (IS_ROM),
        .IS_SAVERAM       (IS_SAVERAM),
        .MAP_VALID        (MAP_VALID),
        .SAVERAM_DIRTY    (SAVERAM_DIRTY),
        .DIRTY_CLR        (DIRTY_CLR),
        .SAVE_QUIET       (SAVE_QUIET)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] addr;
        logic        rom;
        logic        save;
        bit          chk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (MAP_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_map_valid", 32'(MAP_VALID), 0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk)
                    check("rom_addr", 32'(ROM_ADDR), 32'(mon_e.addr));
                check("is_rom", 32'(IS_ROM), 32'(mon_e.rom));
                check("is_saveram", 32'(IS_SAVERAM), 32'(mon_e.save));
                check("rom_hit", 32'(ROM_HIT),
                      32'(mon_e.rom | mon_e.save));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [23:0] a, input logic wr,
                        input logic [23:0] ea, input logic er,
                        input logic es, input bit ck);
        exp_t e;
        e.addr = ea;
        e.rom  = er;
        e.save = es;
        e.chk  = ck;
        exp_q.push_back(e);
        ADDR_STB  = 1'b1;
        SNES_ADDR = a;
        SNES_WR   = wr;
        tick();
        ADDR_STB  = 1'b0;
        SNES_WR   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            tick();
        check("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic load_cfg(input logic [2:0] m, input logic [23:0] sm,
                            input logic [23:0] rm, input string name);
        bit got;
        CFG_MAPPER       = m;
        CFG_SAVERAM_MASK = sm;
        CFG_ROM_MASK     = rm;
        CFG_STB          = 1'b1;
        tick();
        CFG_STB = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (CFG_ACK) got = 1;
            tick();
        end
        check(name, 32'(got), 1);
    endtask

    function automatic logic [31:0] outs();
        return {1'b0, ROM_ADDR, ROM_HIT, IS_ROM, IS_SAVERAM,
                MAP_VALID, CFG_ACK, SAVERAM_DIRTY, SAVE_QUIET};
    endfunction

    initial begin
        int n;
        int q;
        bit got;
        RST = 1'b1;
        SNES_ADDR = '0;
        ADDR_STB = 1'b0;
        SNES_WR = 1'b0;
        CFG_MAPPER = '0;
        CFG_SAVERAM_MASK = '0;
        CFG_ROM_MASK = '0;
        CFG_STB = 1'b0;
        DIRTY_CLR = 1'b0;
        repeat (3) tick();
        @(negedge CLK);
        check("reset_outputs", outs(), 0);
        tick();
        RST = 1'b0;

        // Reset config: Menu, SMASK 0, RMASK FFFFFF.
        send(24'h307FFF, 0, 24'hFF0000, 0, 1, 1);
        send(24'h408000, 0, 24'h008000, 1, 0, 1);
        drain();

        load_cfg(3'd3, 24'h001FFF, 24'hFFFFFF, "cfg_ack_menu");
        send(24'h307FFF, 0, 24'hFF1FFF, 0, 1, 1);
        send(24'h408000, 0, 24'h008000, 1, 0, 1);
        drain();

        load_cfg(3'd3, 24'h001FFF, 24'h3FFFFF, "cfg_ack_menu2");
        send(24'h408000, 0, 24'hC08000, 1, 0, 1);
        send(24'h001234, 0, 24'h000000, 0, 0, 0);
        drain();

        // HiROM request lands mid-stream; stream stays Menu-decoded.
        CFG_MAPPER = 3'd0;
        CFG_SAVERAM_MASK = 24'h001FFF;
        CFG_ROM_MASK = 24'h3FFFFF;
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.addr = 24'hC08000;
            e.rom = 1'b1;
            e.save = 1'b0;
            e.chk = 1'b1;
            exp_q.push_back(e);
            ADDR_STB = 1'b1;
            SNES_ADDR = 24'h408000;
            CFG_STB = (i == 2);
            @(negedge CLK);
            check("ack_held_off", 32'(CFG_ACK), 0);
            tick();
        end
        ADDR_STB = 1'b0;
        CFG_STB = 1'b0;
        n = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            n++;
            @(negedge CLK);
            if (CFG_ACK) got = 1;
            tick();
        end
        check("cfg_ack_hirom", 32'(got), 1);
        check("cfg_ack_idle_cycles", 32'(n), 3);
        drain();

        // HiROM decode.
        send(24'hC01234, 0, 24'h001234, 1, 0, 1);
        send(24'h312345, 0, 24'h000000, 0, 0, 0);
        send(24'h306000, 0, 24'hFF0000, 0, 1, 1);
        drain();
        @(negedge CLK);
        check("read_not_dirty", 32'(SAVERAM_DIRTY), 0);
        tick();

        // Save write then quiet timeout.
        send(24'h306000, 1, 24'hFF0000, 0, 1, 1);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            got = SAVERAM_DIRTY;
        end
        check("dirty_set", 32'(got), 1);
        n = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            n++;
            got = SAVE_QUIET;
        end
        check("save_quiet_seen", 32'(got), 1);
        check("save_quiet_delay", 32'(n), 16);
        q = 0;
        repeat (20) begin
            @(negedge CLK);
            if (SAVE_QUIET) q++;
        end
        check("save_quiet_once", 32'(q), 0);
        check("dirty_held", 32'(SAVERAM_DIRTY), 1);
        tick();

        // Clear racing a save write: set wins.
        send(24'h306000, 1, 24'hFF0000, 0, 1, 1);
        tick();
        DIRTY_CLR = 1'b1;
        @(negedge CLK);
        check("clr_race_map_valid", 32'(MAP_VALID), 1);
        tick();
        DIRTY_CLR = 1'b0;
        @(negedge CLK);
        check("dirty_set_wins", 32'(SAVERAM_DIRTY), 1);
        tick();
        DIRTY_CLR = 1'b1;
        tick();
        DIRTY_CLR = 1'b0;
        @(negedge CLK);
        check("dirty_cleared", 32'(SAVERAM_DIRTY), 0);
        q = 0;
        repeat (20) begin
            @(negedge CLK);
            if (SAVE_QUIET) q++;
        end
        check("no_quiet_when_clean", 32'(q), 0);
        tick();
        drain();

        // ExHiROM, save address wraps past 2^24.
        load_cfg(3'd2, 24'h0FFFFF, 24'hFFFFFF, "cfg_ack_exhirom");
        send(24'hB16000, 0, 24'h012000, 0, 1, 1);
        send(24'h408000, 0, 24'h408000, 1, 0, 1);
        send(24'hC08000, 0, 24'h008000, 1, 0, 1);
        drain();

        // LoROM back-to-back.
        load_cfg(3'd1, 24'h007FFF, 24'h3FFFFF, "cfg_ack_lorom");
        send(24'h018000, 0, 24'h008000, 1, 0, 1);
        send(24'h7E1234, 0, 24'h000000, 0, 0, 0);
        send(24'h700010, 0, 24'hFF0010, 0, 1, 1);
        send(24'h7F8000, 0, 24'h3F8000, 1, 0, 1);
        send(24'h400000, 0, 24'h200000, 1, 0, 1);
        send(24'h700010, 1, 24'hFF0010, 0, 1, 1);
        drain();

        // Reset one cycle after a strobe drops it.
        ADDR_STB = 1'b1;
        SNES_ADDR = 24'h408000;
        tick();
        ADDR_STB = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        q = 0;
        repeat (4) begin
            @(negedge CLK);
            if (MAP_VALID) q++;
        end
        check("rst_drop_map_valid", 32'(q), 0);
        check("rst_mid_outputs", outs(), 0);
        tick();
        send(24'h408000, 0, 24'h008000, 1, 0, 1);
        send(24'h307FFF, 0, 24'hFF0000, 0, 1, 1);
        drain();

        // Reserved mode: no flags, zero address, still valid.
        load_cfg(3'd5, 24'hFFFFFF, 24'hFFFFFF, "cfg_ack_reserved");
        send(24'hC08000, 0, 24'h000000, 0, 0, 1);
        send(24'h306000, 0, 24'h000000, 0, 0, 1);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
